// File: rtl/dev_bus_pkg.sv
// rtl/dev_bus_pkg.sv - shared bus constants, CTRL bit layout and tx FSM encoding
package dev_bus_pkg;

  localparam int DBITS = 32;

  localparam logic [DBITS-1:0] UART_TX_DATA_ADDR = 32'hF000_0020;
  localparam logic [DBITS-1:0] UART_TX_CTRL_ADDR = 32'hF000_0120;

  // CTRL bit positions, common to the key input device and the uart transmitter
  localparam int READY_BIT   = 0;
  localparam int BUSY_BIT    = 1;
  localparam int OVERRUN_BIT = 2;
  localparam int IE_BIT      = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Assemble a CTRL read word; unlisted bits read as zero
  function automatic logic [DBITS-1:0] ctrl_word(input logic ready, input logic busy,
                                                 input logic overrun, input logic ie);
    logic [DBITS-1:0] w;
    w              = '0;
    w[READY_BIT]   = ready;
    w[BUSY_BIT]    = busy;
    w[OVERRUN_BIT] = overrun;
    w[IE_BIT]      = ie;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous show-ahead byte FIFO with wrap-bit pointers
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     init,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // Fullness/emptiness are pre-edge, so a push into a full FIFO is dropped even with a pop
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next pointer and storage values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Pointer registers; init flushes the FIFO
  always_ff @(posedge clk) begin
    if (init) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers decide what is valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_dev.sv
// rtl/uart_tx_dev.sv - memory-mapped 8N1 serial transmitter with byte FIFO
module uart_tx_dev
  import dev_bus_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             init,
  input  logic [DBITS-1:0] abus,
  inout  wire  [DBITS-1:0] dbus,
  input  logic             we,
  output logic             intr,
  output logic             txd
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e        state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             ie_q, ie_d;
  logic             ovr_q, ovr_d;
  logic [7:0]       last_q, last_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic [7:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  logic             sel_data;
  logic             sel_ctrl;
  logic             wr_data;
  logic             wr_ctrl;
  logic             rd_en;
  logic [DBITS-1:0] rd_data;
  logic             ready;
  logic             busy;
  logic             baud_last;
  logic             unused_bus_bits;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .init  (init),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (dbus[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign sel_data  = (abus == UART_TX_DATA_ADDR);
  assign sel_ctrl  = (abus == UART_TX_CTRL_ADDR);
  assign wr_data   = we && sel_data;
  assign wr_ctrl   = we && sel_ctrl;
  assign fifo_push = wr_data;
  assign rd_en     = !we && (sel_data || sel_ctrl);

  assign ready     = !fifo_full;
  assign busy      = (state_q != TX_IDLE) || (fifo_count != '0);
  assign intr      = ready && ie_q;
  assign txd       = txd_q;
  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

  assign unused_bus_bits = ^dbus[DBITS-1:IE_BIT+1];

  // Read mux; the bus is released whenever this device is not being read
  always_comb begin
    rd_data = '0;
    if (sel_ctrl) begin
      rd_data = ctrl_word(ready, busy, ovr_q, ie_q);
    end else begin
      rd_data[7:0] = last_q;
    end
  end

  assign dbus = rd_en ? rd_data : {DBITS{1'bz}};

  // Register-side next state: IE, sticky OVERRUN (set beats clear), last accepted byte
  always_comb begin
    ie_d   = ie_q;
    ovr_d  = ovr_q;
    last_d = last_q;
    if (wr_ctrl) begin
      ie_d = dbus[IE_BIT];
      if (!dbus[OVERRUN_BIT]) begin
        ovr_d = 1'b0;
      end
    end
    if (wr_data) begin
      if (fifo_full) begin
        ovr_d = 1'b1;
      end else begin
        last_d = dbus[7:0];
      end
    end
  end

  // Serializer next state: start bit, 8 data bits LSB first, stop bit, chaining frames
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    fifo_pop = 1'b0;
    case (state_q)
      TX_IDLE: begin
        baud_d = '0;
        txd_d  = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          txd_d    = 1'b0;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        if (baud_last) begin
          baud_d  = '0;
          txd_d   = shift_q[0];
          bit_d   = 3'd0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      TX_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = TX_STOP;
          end else begin
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      TX_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            txd_d    = 1'b0;
            state_d  = TX_START;
          end else begin
            txd_d   = 1'b1;
            state_d = TX_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        baud_d  = '0;
        txd_d   = 1'b1;
        state_d = TX_IDLE;
      end
    endcase
  end

  // State registers; init aborts any frame and returns the line to idle-high
  always_ff @(posedge clk) begin
    if (init) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      ie_q    <= 1'b0;
      ovr_q   <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      ie_q    <= ie_d;
      ovr_q   <= ovr_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_dev.sv
// tb/tb_uart_tx_dev.sv - directed self-checking bench for uart_tx_dev
module tb_uart_tx_dev;
  import dev_bus_pkg::*;

  localparam int CPB = 4;
  localparam logic [31:0] DA = 32'hF000_0020;
  localparam logic [31:0] CA = 32'hF000_0120;

  logic        clk = 1'b0;
  logic        init;
  logic        we;
  logic [31:0] abus;
  logic [31:0] tb_wdata;
  logic        tb_drive;
  wire  [31:0] dbus;
  logic        intr;
  logic        txd;

  int unsigned cyc = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  assign dbus = tb_drive ? tb_wdata : 32'hzzzz_zzzz;

  uart_tx_dev #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk  (clk),
    .init (init),
    .abus (abus),
    .dbus (dbus),
    .we   (we),
    .intr (intr),
    .txd  (txd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_intr;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    abus     = addr;
    tb_wdata = data;
    tb_drive = 1'b1;
    we       = 1'b1;
    tick();
    we       = 1'b0;
    tb_drive = 1'b0;
    abus     = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    we   = 1'b0;
    abus = addr;
    #1;
    data = dbus;
    abus = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [9:0]  frame;
    logic [19:0] bb;
    logic [7:0]  ob [6];
    int          bad;
    int          busy_bad;
    int unsigned e0;
    int          n;

    vecs[0]  = '{"rd_ctrl_reset",   1'b0, CA,               32'h0,        32'h1,   1'b0};
    vecs[1]  = '{"rd_data_reset",   1'b0, DA,               32'h0,        32'h0,   1'b0};
    vecs[2]  = '{"wr_ie_on",        1'b1, CA,               32'h100,      32'h0,   1'b1};
    vecs[3]  = '{"rd_ctrl_ie",      1'b0, CA,               32'h0,        32'h101, 1'b1};
    vecs[4]  = '{"wr_all_ones",     1'b1, CA,               32'hFFFF_FFFF, 32'h0,  1'b1};
    vecs[5]  = '{"rd_ctrl_ro_bits", 1'b0, CA,               32'h0,        32'h101, 1'b1};
    vecs[6]  = '{"wr_ie_off",       1'b1, CA,               32'h0000_FEFF, 32'h0,  1'b0};
    vecs[7]  = '{"rd_ctrl_ie_off",  1'b0, CA,               32'h0,        32'h1,   1'b0};
    vecs[8]  = '{"wr_undecoded",    1'b1, 32'hF000_0024,    32'h77,       32'h0,   1'b0};
    vecs[9]  = '{"rd_data_nopush",  1'b0, DA,               32'h0,        32'h0,   1'b0};
    vecs[10] = '{"rd_ctrl_nopush",  1'b0, CA,               32'h0,        32'h1,   1'b0};

    init = 1'b1; we = 1'b0; abus = 32'h0; tb_wdata = 32'h0; tb_drive = 1'b0;
    repeat (2) tick();
    check("reset_txd", {31'h0, txd}, 32'h1);
    check("reset_intr", {31'h0, intr}, 32'h0);
    init = 1'b0;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_wr) begin
        bus_write(vecs[i].addr, vecs[i].data);
      end else begin
        bus_read(vecs[i].addr, rd);
        check(vecs[i].name, rd, vecs[i].exp_rd);
      end
      check({vecs[i].name, "_intr"}, {31'h0, intr}, {31'h0, vecs[i].exp_intr});
    end

    // single frame, upper data bits must be ignored
    bus_write(DA, 32'hFFFF_FFA5);
    check("sb_txd_edge_e", {31'h0, txd}, 32'h1);
    bus_read(CA, rd);
    check("sb_ctrl_queued", rd, 32'h3);
    frame = {1'b1, 8'hA5, 1'b0};
    busy_bad = 0;
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        tick();
        if (txd !== frame[b]) bad++;
        bus_read(CA, rd);
        if (rd[BUSY_BIT] !== 1'b1) busy_bad++;
      end
      check($sformatf("sb_bit%0d_bad_cycles", b), bad, 0);
    end
    check("sb_busy_during_frame", busy_bad, 0);
    tick();
    check("sb_txd_after", {31'h0, txd}, 32'h1);
    bus_read(CA, rd);
    check("sb_ctrl_after", rd, 32'h1);
    bus_read(DA, rd);
    check("sb_data_last", rd, 32'hA5);

    // back-to-back frames with no idle gap
    bb = {1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0};
    bus_write(DA, 32'h55);
    bus_write(DA, 32'h0F);
    bad = 0;
    if (txd !== bb[0]) bad++;
    for (int k = 1; k < 80; k++) begin
      tick();
      if (txd !== bb[k / CPB]) bad++;
      if (k == 39) check("bb_stop1", {31'h0, txd}, 32'h1);
      if (k == 40) check("bb_no_gap_start2", {31'h0, txd}, 32'h0);
      if (k == 79) begin
        bus_read(CA, rd);
        check("bb_busy_last_cycle", rd, 32'h3);
      end
    end
    check("bb_stream_bad_cycles", bad, 0);
    tick();
    bus_read(CA, rd);
    check("bb_ctrl_idle", rd, 32'h1);
    check("bb_txd_idle", {31'h0, txd}, 32'h1);

    // overrun: 1 popped + 4 queued + 1 dropped
    ob = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    bus_write(DA, {24'h0, ob[0]});
    e0 = cyc;
    for (int i = 1; i < 6; i++) bus_write(DA, {24'h0, ob[i]});
    bus_read(CA, rd);
    check("ovr_ctrl_full", rd, 32'h6);
    bus_read(DA, rd);
    check("ovr_data_last_accepted", rd, 32'h55);
    bus_write(CA, 32'h104);
    bus_read(CA, rd);
    check("ovr_keep_on_write1", rd, 32'h106);
    check("intr_full_ie", {31'h0, intr}, 32'h0);
    bus_write(CA, 32'h100);
    bus_read(CA, rd);
    check("ovr_clear_write0", rd, 32'h102);
    n = 0;
    while (!intr && n < 200) begin
      tick();
      n++;
    end
    check("intr_rise_cycle", cyc, e0 + 41);
    check("intr_pop_start_bit", {31'h0, txd}, 32'h0);
    bus_write(CA, 32'h0);
    check("intr_ie_off", {31'h0, intr}, 32'h0);

    n = 0;
    bus_read(CA, rd);
    while (rd[BUSY_BIT] && n < 400) begin
      tick();
      n++;
      bus_read(CA, rd);
    end
    check("drain_ctrl_idle", rd, 32'h1);

    // reset during data bit 3 of 0xA5 with a second byte queued
    bus_write(DA, 32'hA5);
    bus_write(DA, 32'h81);
    repeat (17) tick();
    check("rst_mid_bit3_low", {31'h0, txd}, 32'h0);
    init = 1'b1;
    tick();
    check("rst_mid_txd", {31'h0, txd}, 32'h1);
    init = 1'b0;
    bus_read(CA, rd);
    check("rst_mid_ctrl", rd, 32'h1);
    bus_read(DA, rd);
    check("rst_mid_data", rd, 32'h0);
    check("rst_mid_intr", {31'h0, intr}, 32'h0);
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (txd !== 1'b1) bad++;
    end
    check("rst_mid_no_restart", bad, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
